avalon_ram_waitstate: RTL and testbench

//  Single-port word RAM acting as the Avalon-MM slave for top_level_cpu; the CPU's instruction and data memory.

---
 rtl/avalon_ram_waitstate.sv | 148 ++++++++++++++
 tb/tb_avalon_ram_waitstate.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/avalon_ram_waitstate.sv
// Avalon-MM word RAM slave with a programmable number of waitrequest cycles per
// transfer, byte-lane writes, a sticky protocol-error flag and a separate
// synchronous preload port used to load a program while the CPU is held in reset.
module avalon_ram_waitstate #(
    parameter int    ADDR_WIDTH  = 8,
    parameter int    WAIT_CYCLES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [3:0]            byteenable,
    output logic                  waitrequest,
    output logic [31:0]           readdata,
    input  logic                  inst_input,
    input  logic [ADDR_WIDTH+1:0] inst_addr,
    input  logic [31:0]           instruction,
    output logic                  prot_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    // Values captured when a request is accepted; the transfer uses these even
    // if the master changes its outputs while stalled.
    logic [31:0] r_addr;
    logic        r_write;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;

    logic [31:0] r_mem [DEPTH];

    logic                  w_req;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_commit;
    logic                  w_proto;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [ADDR_WIDTH-1:0] w_lat_idx;
    logic [ADDR_WIDTH-1:0] w_pre_idx;
    logic                  w_unused_bits;

    assign w_req     = read | write;
    assign w_idx     = address[ADDR_WIDTH+1:2];
    assign w_lat_idx = r_addr[ADDR_WIDTH+1:2];
    assign w_pre_idx = inst_addr[ADDR_WIDTH+1:2];

    // Byte offset of the preload address is meaningless for whole-word loads.
    assign w_unused_bits = &{1'b0, inst_addr[1:0]};

    // A single, unambiguous request is accepted only while the preload port is idle.
    assign w_accept = (r_state == S_IDLE) & (read ^ write) & ~inst_input;
    // Completion edge: still requested, no stall cycles left.
    assign w_done   = (r_state == S_BUSY) & w_req & (r_cnt == 4'd0);
    // A reset on the completion edge aborts the write.
    assign w_commit = w_done & r_write & ~reset;

    // Conflicting read/write, or master outputs drifting away from the latched transfer.
    assign w_proto = (read & write)
                   | ((r_state == S_BUSY) & w_req &
                      ((address != r_addr) | (write != r_write) |
                       (r_write & (writedata != r_wdata))));

    // Memory starts zero-filled; programs are loaded through the preload port.
    initial begin
        for (int i = 0; i < DEPTH; i++) r_mem[i] = 32'h0;
    end

    // State register plus transfer capture, read data and sticky error flag.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= 32'h0;
            r_write  <= 1'b0;
            r_wdata  <= 32'h0;
            r_be     <= 4'h0;
            readdata <= 32'h0;
            prot_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_addr  <= address;
                r_write <= write;
                r_wdata <= writedata;
                r_be    <= byteenable;
                if (read) readdata <= r_mem[w_idx];
            end
            if (w_proto) prot_err <= 1'b1;
        end
    end

    // Next-state logic: count down stall cycles, drop back to IDLE on abandon or completion.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = 4'(WAIT_CYCLES);
                end
            end
            S_BUSY: begin
                if (!w_req) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: stall any pending request except on the completion cycle.
    always_comb begin
        waitrequest = w_req & ~((r_state == S_BUSY) & (r_cnt == 4'd0));
    end

    // Memory writes: bus commit per lane, then preload so it wins on the same word.
    always_ff @(posedge clk) begin
        // NOTE: memory contents are deliberately not reset; only control state is.
        if (w_commit) begin
            for (int n = 0; n < 4; n++) begin
                if (r_be[n]) r_mem[w_lat_idx][8*n +: 8] <= r_wdata[8*n +: 8];
            end
        end
        if (inst_input) r_mem[w_pre_idx] <= instruction;
    end

endmodule

// File: tb/tb_avalon_ram_waitstate.sv
// Directed self-checking bench for avalon_ram_waitstate: preload, reads with
// wait states, byte-lane writes, latency per WAIT_CYCLES, protocol errors,
// reset mid-transfer, preload/commit collision and address aliasing.
module tb_avalon_ram_waitstate;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        inst_input;
    logic [9:0]  inst_addr;
    logic [31:0] instruction;
    logic        prot_err;

    // Auxiliary instances for latency with WAIT_CYCLES = 0 and 3.
    logic        rd_aux;
    logic        wr_aux;
    logic        inst_aux;
    logic        wr0, wr3, pe0, pe3;
    logic [31:0] rd0, rd3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    avalon_ram_waitstate #(.ADDR_WIDTH(8), .WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
        .readdata(readdata), .inst_input(inst_input), .inst_addr(inst_addr),
        .instruction(instruction), .prot_err(prot_err)
    );

    avalon_ram_waitstate #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .address(32'h0), .read(rd_aux), .write(wr_aux),
        .writedata(32'h0), .byteenable(4'hF), .waitrequest(wr0),
        .readdata(rd0), .inst_input(inst_aux), .inst_addr(10'h0),
        .instruction(32'h0), .prot_err(pe0)
    );

    avalon_ram_waitstate #(.ADDR_WIDTH(8), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .address(32'h0), .read(rd_aux), .write(wr_aux),
        .writedata(32'h0), .byteenable(4'hF), .waitrequest(wr3),
        .readdata(rd3), .inst_input(inst_aux), .inst_addr(10'h0),
        .instruction(32'h0), .prot_err(pe3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        inst_input  = 1'b1;
        inst_addr   = a;
        instruction = d;
        step();
        inst_input  = 1'b0;
    endtask

    // One bus transfer; waits = number of cycles waitrequest was high (capped at 40).
    task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be, output int waits, output logic [31:0] rd);
        address    = a;
        write      = w;
        read       = ~w;
        writedata  = d;
        byteenable = be;
        waits      = 0;
        #1;
        while (waitrequest && waits < 40) begin
            step();
            waits++;
        end
        rd = readdata;
        step();
        read  = 1'b0;
        write = 1'b0;
    endtask

    initial begin
        int          waits;
        int          n0;
        int          n3;
        logic [31:0] rd;

        reset = 1'b1; read = 1'b0; write = 1'b0; address = 32'h0; writedata = 32'h0;
        byteenable = 4'h0; inst_input = 1'b0; inst_addr = 10'h0; instruction = 32'h0;
        rd_aux = 1'b0; wr_aux = 1'b0; inst_aux = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        check("rst_waitrequest", {31'h0, waitrequest}, 32'h0);
        check("rst_readdata", readdata, 32'h0);
        check("rst_prot_err", {31'h0, prot_err}, 32'h0);

        // Program image plus known-zero scratch words.
        preload(10'h004, 32'h24020010);
        preload(10'h008, 32'h2403FFFB);
        preload(10'h020, 32'h0);
        preload(10'h01C, 32'h0);
        preload(10'h040, 32'h0);

        // Read with one wait cycle: two stall cycles then data.
        bus_xfer(1'b0, 32'h0000_0004, 32'h0, 4'hF, waits, rd);
        check("t1_waits", 32'(waits), 32'd2);
        check("t1_data", rd, 32'h24020010);

        // Upper address bits alias onto the same words.
        bus_xfer(1'b0, 32'hBFC0_0004, 32'h0, 4'hF, waits, rd);
        check("alias_w1", rd, 32'h24020010);
        bus_xfer(1'b0, 32'hBFC0_0008, 32'h0, 4'hF, waits, rd);
        check("alias_w2", rd, 32'h2403FFFB);

        // Byte-lane write lanes 0 and 2.
        bus_xfer(1'b1, 32'h0000_0020, 32'hAABBCCDD, 4'b0101, waits, rd);
        check("t2_write_waits", 32'(waits), 32'd2);
        bus_xfer(1'b0, 32'h0000_0020, 32'h0, 4'hF, waits, rd);
        check("t2_data", rd, 32'h00BB00DD);

        // byteenable 0: normal completion, no change, no error.
        bus_xfer(1'b1, 32'h0000_0020, 32'hFFFFFFFF, 4'b0000, waits, rd);
        bus_xfer(1'b0, 32'h0000_0020, 32'h0, 4'hF, waits, rd);
        check("be0_data", rd, 32'h00BB00DD);
        check("be0_prot_err", {31'h0, prot_err}, 32'h0);

        // Latency: WAIT_CYCLES=0 -> 1 stall, WAIT_CYCLES=3 -> 4 stalls.
        n0 = -1; n3 = -1;
        rd_aux = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (n0 < 0 && !wr0) n0 = k;
            if (n3 < 0 && !wr3) n3 = k;
            step();
        end
        rd_aux = 1'b0;
        check("t3_wait0", 32'(n0), 32'd1);
        check("t3_wait3", 32'(n3), 32'd4);

        // Preload colliding with a bus write commit to the same word: preload wins.
        address = 32'h0000_001C; writedata = 32'hFFFFFFFF; byteenable = 4'hF; write = 1'b1;
        step();                         // accepted, BUSY cnt=1
        step();                         // cnt=0
        inst_input = 1'b1; inst_addr = 10'h01C; instruction = 32'h00000008;
        #1;
        check("t6_complete_cycle", {31'h0, waitrequest}, 32'h0);
        step();                         // commit and preload on the same edge
        inst_input = 1'b0; write = 1'b0;
        bus_xfer(1'b0, 32'h0000_001C, 32'h0, 4'hF, waits, rd);
        check("t6_data", rd, 32'h00000008);

        // Read and write together: stall forever, flag error, memory untouched.
        address = 32'h0000_0020; writedata = 32'h0; byteenable = 4'hF;
        read = 1'b1; write = 1'b1;
        step(); step(); step();
        check("t4_waitrequest", {31'h0, waitrequest}, 32'h1);
        check("t4_prot_err", {31'h0, prot_err}, 32'h1);
        read = 1'b0; write = 1'b0;
        bus_xfer(1'b0, 32'h0000_0020, 32'h0, 4'hF, waits, rd);
        check("t4_mem", rd, 32'h00BB00DD);
        reset = 1'b1; step(); reset = 1'b0;
        #1;
        check("t4_reset_clears", {31'h0, prot_err}, 32'h0);

        // Reset in the middle of a write aborts it.
        bus_xfer(1'b0, 32'h0000_0004, 32'h0, 4'hF, waits, rd);  // readdata nonzero
        address = 32'h0000_0040; writedata = 32'h12345678; byteenable = 4'hF; write = 1'b1;
        step();                         // BUSY
        reset = 1'b1;
        step();
        reset = 1'b0; write = 1'b0;
        #1;
        check("t5_waitrequest", {31'h0, waitrequest}, 32'h0);
        check("t5_readdata", readdata, 32'h0);
        bus_xfer(1'b0, 32'h0000_0040, 32'h0, 4'hF, waits, rd);
        check("t5_mem", rd, 32'h0);

        // Master changes address while stalled: latched address is used, error flagged.
        address = 32'h0000_0004; read = 1'b1;
        step();                         // accepted
        address = 32'h0000_0008;
        step();                         // cnt=0
        #1;
        check("chg_waitrequest", {31'h0, waitrequest}, 32'h0);
        check("chg_data", readdata, 32'h24020010);
        step();
        read = 1'b0;
        check("chg_prot_err", {31'h0, prot_err}, 32'h1);

        // Preload on a reset edge still writes.
        reset = 1'b1; inst_input = 1'b1; inst_addr = 10'h030; instruction = 32'hCAFEF00D;
        step();
        reset = 1'b0; inst_input = 1'b0;
        bus_xfer(1'b0, 32'h0000_0030, 32'h0, 4'hF, waits, rd);
        check("rst_preload", rd, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
